// File: rtl/multicycle_datapath_if.sv
// -----------------------------------------------------------------------------
// multicycle_datapath_if
//
// Purpose: groups the control-unit step selects, operand bus and result/status
// bus of the multicycle datapath into one bundle.
//
// Handshake semantics: there is no back-pressure. "start" is a request sampled
// only while the datapath is idle (busy=0). "result_valid" is a single-cycle
// pulse; result/overflow/sel_error are valid and stable from that cycle until
// the next completed run (sel_error until the next accepted start). The
// consumer must capture the result in the pulse cycle or read the held value.
//
// Signals:
//   start, a_in..d_in               request and operands (master -> slave)
//   s0, s1, s2, addOrSub, done      control-unit step selects (master -> slave)
//   result, result_valid, overflow  completed-run result      (slave -> master)
//   sel_error, busy, step_count     run status                (slave -> master)
//   dbg_run                         FSM state, 1 = RUN        (slave -> master)
//
// Modports:
//   master : control unit / stimulus side
//   slave  : datapath side
// -----------------------------------------------------------------------------
interface multicycle_datapath_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [WIDTH-1:0] c_in;
    logic [WIDTH-1:0] d_in;
    logic             s0;
    logic             s1;
    logic             s2;
    logic             addOrSub;
    logic             done;

    logic [WIDTH-1:0] result;
    logic             result_valid;
    logic             overflow;
    logic             sel_error;
    logic             busy;
    logic [2:0]       step_count;
    logic             dbg_run;

    modport master (
        output start, a_in, b_in, c_in, d_in,
        output s0, s1, s2, addOrSub, done,
        input  result, result_valid, overflow, sel_error, busy, step_count,
        input  dbg_run
    );

    modport slave (
        input  start, a_in, b_in, c_in, d_in,
        input  s0, s1, s2, addOrSub, done,
        output result, result_valid, overflow, sel_error, busy, step_count,
        output dbg_run
    );
endinterface

// File: rtl/multicycle_datapath.sv
// -----------------------------------------------------------------------------
// multicycle_datapath
//
// Purpose: signed accumulate datapath driven by the multicycle control unit.
// On start it latches four operands and loads the accumulator with A. While
// running, each clock performs one control-unit step:
//   s0=0                  reload accumulator from latched A
//   s0=1, {s2,s1}=00/01/10 accumulate +/- B/C/D (addOrSub: 1=add, 0=sub)
//   s0=1, {s2,s1}=11      reserved: accumulator holds, sel_error set
// A rising edge on done publishes the accumulator as the result together with
// the sticky overflow flag and returns to idle. Mode 0 (A+B+C-D) and mode 1
// (A-B+C+D) are just different step sequences from the control unit.
//
// Ports:
//   clock   rising-edge clock
//   reset   synchronous active-high reset
//   bus     multicycle_datapath_if.slave (operands, selects, result, status)
//
// Parameters:
//   WIDTH   operand/accumulator/result width, two's complement
// -----------------------------------------------------------------------------
module multicycle_datapath #(
    parameter int WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    multicycle_datapath_if.slave  bus
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           state;

    // Operand registers: the run uses only these, never the live inputs.
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] c_q;
    logic [WIDTH-1:0] d_q;

    logic [WIDTH-1:0] acc;
    logic             sticky_ovf;
    logic             done_q;

    logic [WIDTH-1:0] result_r;
    logic             result_valid_r;
    logic             overflow_r;
    logic             sel_error_r;
    logic             busy_r;
    logic [2:0]       step_count_r;

    // Step arithmetic
    logic [WIDTH-1:0] step_op;
    logic [WIDTH-1:0] step_sum;
    logic             step_ovf;
    logic             done_edge;
    logic             sel_reserved;

    assign done_edge    = bus.done && !done_q;
    assign sel_reserved = bus.s2 && bus.s1;

    always_comb begin
        step_op  = b_q;
        step_sum = '0;
        step_ovf = 1'b0;

        unique case ({bus.s2, bus.s1})
            2'b01:   step_op = c_q;
            2'b10:   step_op = d_q;
            default: step_op = b_q;
        endcase

        if (bus.addOrSub) begin
            step_sum = acc + step_op;
            // Same-sign operands whose sum flips sign.
            step_ovf = (acc[WIDTH-1] == step_op[WIDTH-1]) &&
                       (step_sum[WIDTH-1] != acc[WIDTH-1]);
        end else begin
            step_sum = acc - step_op;
            // Opposite-sign operands whose difference leaves acc's sign.
            step_ovf = (acc[WIDTH-1] != step_op[WIDTH-1]) &&
                       (step_sum[WIDTH-1] != acc[WIDTH-1]);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= ST_IDLE;
            a_q            <= '0;
            b_q            <= '0;
            c_q            <= '0;
            d_q            <= '0;
            acc            <= '0;
            sticky_ovf     <= 1'b0;
            done_q         <= 1'b0;
            result_r       <= '0;
            result_valid_r <= 1'b0;
            overflow_r     <= 1'b0;
            sel_error_r    <= 1'b0;
            busy_r         <= 1'b0;
            step_count_r   <= 3'd0;
        end else begin
            result_valid_r <= 1'b0;

            unique case (state)
                ST_IDLE: begin
                    // Selects and done are ignored while idle.
                    if (bus.start) begin
                        a_q          <= bus.a_in;
                        b_q          <= bus.b_in;
                        c_q          <= bus.c_in;
                        d_q          <= bus.d_in;
                        acc          <= bus.a_in;
                        step_count_r <= 3'd0;
                        sticky_ovf   <= 1'b0;
                        sel_error_r  <= 1'b0;
                        // A done level already high at entry still counts as an edge.
                        done_q       <= 1'b0;
                        busy_r       <= 1'b1;
                        state        <= ST_RUN;
                    end
                end

                ST_RUN: begin
                    done_q <= bus.done;
                    // start is ignored here; operands stay as latched.
                    if (done_edge) begin
                        // Completion takes precedence over any step this cycle.
                        result_r       <= acc;
                        overflow_r     <= sticky_ovf;
                        result_valid_r <= 1'b1;
                        busy_r         <= 1'b0;
                        state          <= ST_IDLE;
                    end else if (!bus.s0) begin
                        acc          <= a_q;
                        step_count_r <= 3'd0;
                        sticky_ovf   <= 1'b0;
                    end else if (sel_reserved) begin
                        sel_error_r <= 1'b1;
                    end else begin
                        acc        <= step_sum;
                        sticky_ovf <= sticky_ovf | step_ovf;
                        if (step_count_r != 3'd7) begin
                            step_count_r <= step_count_r + 3'd1;
                        end
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.result       = result_r;
    assign bus.result_valid = result_valid_r;
    assign bus.overflow     = overflow_r;
    assign bus.sel_error    = sel_error_r;
    assign bus.busy         = busy_r;
    assign bus.step_count   = step_count_r;
    assign bus.dbg_run      = (state == ST_RUN);

endmodule

// File: tb/tb_multicycle_datapath.sv
// -----------------------------------------------------------------------------
// tb_multicycle_datapath
//
// Directed bench for multicycle_datapath (WIDTH=8). The driver issues control
// unit step sequences and pushes the hand-computed expected completion record
// {result, overflow, sel_error, step_count} into exp_q; a monitor pops and
// compares on every result_valid pulse. Status signals are checked directly.
// -----------------------------------------------------------------------------
module tb_multicycle_datapath;

    localparam int WIDTH = 8;
    localparam int EW    = WIDTH + 5;

    logic clock;
    logic reset;

    multicycle_datapath_if #(.WIDTH(WIDTH)) bus ();

    multicycle_datapath #(.WIDTH(WIDTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks   = 0;
    int errors   = 0;
    int rv_count = 0;

    logic [EW-1:0] exp_q[$];

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
        $fatal(1, "timeout");
    end

    // ---------------- helpers ----------------
    function automatic logic [EW-1:0] pack(input logic [WIDTH-1:0] r, input logic ov,
                                           input logic se, input logic [2:0] sc);
        return {r, ov, se, sc};
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        bus.start    = 1'b0;
        bus.s0       = 1'b0;
        bus.s1       = 1'b0;
        bus.s2       = 1'b0;
        bus.addOrSub = 1'b0;
        bus.done     = 1'b0;
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_start(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic [WIDTH-1:0] c, input logic [WIDTH-1:0] d);
        bus.a_in  = a;
        bus.b_in  = b;
        bus.c_in  = c;
        bus.d_in  = d;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic do_step(input logic s0v, input logic [1:0] sel, input logic addv);
        bus.s0       = s0v;
        {bus.s2, bus.s1} = sel;
        bus.addOrSub = addv;
        tick();
    endtask

    task automatic do_done(input int n);
        bus.done = 1'b1;
        repeat (n) tick();
        idle_inputs();
    endtask

    // mode 0: A+B+C-D, mode 1: A-B+C+D
    task automatic run_mode(input bit mode);
        do_step(1'b0, 2'b00, 1'b0);
        do_step(1'b1, 2'b00, mode ? 1'b0 : 1'b1);
        do_step(1'b1, 2'b01, 1'b1);
        do_step(1'b1, 2'b10, mode ? 1'b1 : 1'b0);
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clock) begin
        if (!reset && bus.result_valid === 1'b1) begin
            logic [EW-1:0] act;
            logic [EW-1:0] exp;
            rv_count++;
            act = {bus.result, bus.overflow, bus.sel_error, bus.step_count};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_result: got %0h expected no result_valid", act);
            end else begin
                exp = exp_q.pop_front();
                if (act !== exp) begin
                    errors++;
                    $display("FAIL result_record: got %0h expected %0h", act, exp);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int rv_before;
        idle_inputs();
        bus.a_in = '0;
        bus.b_in = '0;
        bus.c_in = '0;
        bus.d_in = '0;
        reset = 1'b1;
        tick();
        tick();
        check("reset_result",     16'(bus.result),       16'h0);
        check("reset_valid",      16'(bus.result_valid), 16'h0);
        check("reset_overflow",   16'(bus.overflow),     16'h0);
        check("reset_sel_error",  16'(bus.sel_error),    16'h0);
        check("reset_busy",       16'(bus.busy),         16'h0);
        check("reset_step_count", 16'(bus.step_count),   16'h0);
        reset = 1'b0;
        tick();

        // Mode 0: 10+20+5-3 = 32
        exp_q.push_back(pack(8'h20, 1'b0, 1'b0, 3'd3));
        do_start(8'd10, 8'd20, 8'd5, 8'd3);
        check("m0_busy_after_start", 16'(bus.busy), 16'h1);
        run_mode(1'b0);
        check("m0_steps_before_done", 16'(bus.step_count), 16'h3);
        do_done(1);
        check("m0_busy_falls", 16'(bus.busy), 16'h0);
        tick();
        tick();
        check("m0_result_held", 16'(bus.result), 16'h20);

        // Mode 1: 10-20+5+3 = -2
        exp_q.push_back(pack(8'hFE, 1'b0, 1'b0, 3'd3));
        do_start(8'd10, 8'd20, 8'd5, 8'd3);
        run_mode(1'b1);
        do_done(1);
        tick();

        // Overflow: 100+50 wraps to 0x96, then a clean run clears it
        exp_q.push_back(pack(8'h96, 1'b1, 1'b0, 3'd3));
        do_start(8'd100, 8'd50, 8'd0, 8'd0);
        run_mode(1'b0);
        do_done(1);
        tick();
        check("ovf_held_idle", 16'(bus.overflow), 16'h1);
        exp_q.push_back(pack(8'h20, 1'b0, 1'b0, 3'd3));
        do_start(8'd10, 8'd20, 8'd5, 8'd3);
        run_mode(1'b0);
        do_done(1);
        tick();

        // Reset mid-run: no result, everything back to zero
        do_start(8'd10, 8'd20, 8'd5, 8'd3);
        do_step(1'b0, 2'b00, 1'b0);
        do_step(1'b1, 2'b00, 1'b1);
        do_step(1'b1, 2'b01, 1'b1);
        rv_before = rv_count;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        idle_inputs();
        check("midrst_busy",       16'(bus.busy),       16'h0);
        check("midrst_step_count", 16'(bus.step_count), 16'h0);
        check("midrst_result",     16'(bus.result),     16'h0);
        tick();
        tick();
        check("midrst_no_valid", 16'(rv_count - rv_before), 16'h0);
        exp_q.push_back(pack(8'h02, 1'b0, 1'b0, 3'd3));
        do_start(8'd1, 8'd1, 8'd1, 8'd1);
        run_mode(1'b0);
        do_done(1);
        tick();

        // Stability: live inputs change and start pulses during RUN
        exp_q.push_back(pack(8'h20, 1'b0, 1'b0, 3'd3));
        do_start(8'd10, 8'd20, 8'd5, 8'd3);
        bus.a_in  = 8'hFF;
        bus.b_in  = 8'hFF;
        bus.c_in  = 8'hFF;
        bus.d_in  = 8'hFF;
        bus.start = 1'b1;
        do_step(1'b0, 2'b00, 1'b0);
        do_step(1'b1, 2'b00, 1'b1);
        bus.start = 1'b0;
        do_step(1'b1, 2'b01, 1'b1);
        do_step(1'b1, 2'b10, 1'b0);
        do_done(1);
        tick();

        // Reserved select mid-run, done held for three cycles
        exp_q.push_back(pack(8'h20, 1'b0, 1'b1, 3'd3));
        do_start(8'd10, 8'd20, 8'd5, 8'd3);
        do_step(1'b0, 2'b00, 1'b0);
        do_step(1'b1, 2'b00, 1'b1);
        do_step(1'b1, 2'b11, 1'b1);
        check("rsv_sel_error",  16'(bus.sel_error),  16'h1);
        check("rsv_step_hold",  16'(bus.step_count), 16'h1);
        do_step(1'b1, 2'b01, 1'b1);
        do_step(1'b1, 2'b10, 1'b0);
        rv_before = rv_count;
        do_done(3);
        tick();
        tick();
        check("long_done_one_pulse", 16'(rv_count - rv_before), 16'h1);

        // Next start clears sel_error; immediate done publishes A with 0 steps
        exp_q.push_back(pack(8'h5A, 1'b0, 1'b0, 3'd0));
        do_start(8'h5A, 8'd1, 8'd2, 8'd3);
        check("start_clears_sel_error", 16'(bus.sel_error), 16'h0);
        do_done(1);
        tick();

        // Step counter saturates at 7 (9 adds of 1)
        exp_q.push_back(pack(8'h09, 1'b0, 1'b0, 3'd7));
        do_start(8'd0, 8'd1, 8'd0, 8'd0);
        do_step(1'b0, 2'b00, 1'b0);
        repeat (9) do_step(1'b1, 2'b00, 1'b1);
        do_done(1);
        tick();
        tick();

        check("scoreboard_drained", 16'(exp_q.size()), 16'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_datapath.md
Name: multicycle_datapath

Overview:
- Arithmetic datapath directly downstream of the multicycle control unit FSM.
- Consumes the FSM's step selects (s0, s1, s2), add/subtract control (addOrSub) and completion flag (done).
- Captures four operands on start, runs a signed accumulate sequence one step per clock, and publishes a registered result with overflow and protocol-error status.
- Sequences: mode 0 computes A+B+C-D; mode 1 computes A-B+C+D. The sequence is selected entirely by the control unit.

Parameters:
- WIDTH, 8, operand/accumulator/result width in bits (two's complement).

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  begin operation; sampled only in IDLE.
- a_in  input  WIDTH  operand A.
- b_in  input  WIDTH  operand B.
- c_in  input  WIDTH  operand C.
- d_in  input  WIDTH  operand D.
- s0  input  1  0 = load accumulator from A; 1 = accumulate step.
- s1  input  1  operand select bit 0; don't-care (may be X) when s0=0.
- s2  input  1  operand select bit 1; don't-care (may be X) when s0=0.
- addOrSub  input  1  1 = add selected operand, 0 = subtract.
- done  input  1  completion flag from the control unit.
- result  output  WIDTH  registered final accumulator value.
- result_valid  output  1  one-cycle pulse when result updates.
- overflow  output  1  signed overflow occurred during the last completed run.
- sel_error  output  1  reserved select {s2,s1}=11 seen during the current/last run.
- busy  output  1  high in RUN state.
- step_count  output  3  accumulate steps executed this run; saturates at 7.

Behaviour:
- Reset: synchronous, evaluated at posedge clock, priority over everything.
  - result=0, result_valid=0, overflow=0, sel_error=0, busy=0, step_count=0.
  - Accumulator, operand registers and sticky overflow cleared; state=IDLE.
  - Reset mid-run aborts the run: no result_valid, result unchanged from 0.
- States: IDLE, RUN.
- IDLE:
  - Selects and done are ignored.
  - On start=1: latch a_in..d_in into operand registers; acc<=a_in; step_count<=0; sticky overflow<=0; sel_error<=0; go to RUN.
  - busy=1 from the next cycle.
- RUN, each posedge, in priority order:
  1. Done edge (done=1 and done registered last cycle =0):
     - result<=acc; overflow<=sticky overflow; result_valid=1 for exactly one cycle; go to IDLE.
     - No accumulate is performed in that cycle (done wins over s0).
  2. s0=0: acc<=latched A; step_count<=0; sticky overflow<=0.
  3. s0=1, {s2,s1}=00/01/10: operand = B/C/D.
     - acc<=acc+op if addOrSub=1, else acc-op; step_count++ (saturating at 7).
     - sticky overflow |= signed overflow of that step.
  4. s0=1, {s2,s1}=11: acc holds; sel_error<=1 (sticky until next start or reset); step_count unchanged.
- done held high across several cycles produces a single result_valid; the edge detector's previous-done register is cleared on reset and on entry to RUN.
- start in RUN is ignored: operands are not re-latched and the run continues.
- Operand inputs may change freely after the start cycle; only latched values are used.
- Arithmetic wraps modulo 2^WIDTH.
  - Add overflow: operands have the same sign and the sum sign differs.
  - Subtract overflow: operands have different signs and the difference sign differs from acc.
- result, overflow and sel_error hold their values in IDLE until the next completed run (result, overflow) or next start (sel_error).
- Latency: start to first possible accumulate is 1 cycle. For a 4-step run (load, 3 accumulates, done edge), result_valid follows start by 5 cycles.

Test Plan (WIDTH=8):
- Mode-0 sum: A=10, B=20, C=5, D=3; start, then s0=0, then (s0=1,sel=00,add), (s0=1,sel=01,add), (s0=1,sel=10,sub), then done=1 -> result=32 (8'h20), result_valid one cycle, overflow=0, step_count=3, busy falls.
- Mode-1 sum: same operands; sequence sub B, add C, add D -> result=8'hFE (-2), overflow=0, sel_error=0.
- Overflow: A=100, B=50, C=0, D=0; mode-0 sequence -> result=8'h96, overflow=1. A following clean run clears overflow to 0.
- Reset mid-run: assert reset after two accumulate steps -> busy=0, step_count=0, result=0, no result_valid. A subsequent full mode-0 run with A=1,B=1,C=1,D=1 -> result=2.
- Stability: change a_in..d_in to 8'hFF and pulse start during RUN -> result still 32 for the mode-0 operands of scenario 1.
- Reserved select plus long done: inject s0=1,{s2,s1}=11 mid-run -> acc unchanged, sel_error=1. Hold done high 3 cycles -> exactly one result_valid pulse.
